// File: rtl/product_accumulator_if.sv
// Product-beat input stream and frame-result output stream for product_accumulator.
// A transfer happens on a rising edge where valid and ready are both 1; valid never waits on ready.
interface product_accumulator_if #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 80,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a frame of unsigned products and holds the total until downstream takes it.
// ACC_SAT_EN: when defined, the accumulator clamps to all-ones on overflow instead of wrapping.
module product_accumulator #(
    parameter int IN_W  = 64,
    parameter int ACC_W = 80,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    product_accumulator_if.slave bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] acc_upd;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_upd;
    logic             ovf;
    logic             ovf_next;
    logic             ovf_upd;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             ovf_q;
    logic             ovf_out_next;
    logic             valid_q;
    logic             valid_next;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic             accept;

    assign bus.in_ready = (state != DONE);
    assign accept       = bus.in_valid && (state != DONE);

    // One extra bit catches the carry out of the accumulator.
    assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
    assign carry    = sum_wide[ACC_W];

`ifdef ACC_SAT_EN
    assign acc_upd = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign acc_upd = sum_wide[ACC_W-1:0];
`endif

    assign ovf_upd = ovf | carry;
    assign cnt_upd = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        ovf_next     = ovf;
        sum_next     = sum_q;
        count_next   = count_q;
        ovf_out_next = ovf_q;
        valid_next   = valid_q;
        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    if (bus.in_last) begin
                        // Publish the post-update totals and start the next frame from zero.
                        sum_next     = acc_upd;
                        count_next   = cnt_upd;
                        ovf_out_next = ovf_upd;
                        valid_next   = 1'b1;
                        acc_next     = '0;
                        cnt_next     = '0;
                        ovf_next     = 1'b0;
                        state_next   = DONE;
                    end else begin
                        acc_next   = acc_upd;
                        cnt_next   = cnt_upd;
                        ovf_next   = ovf_upd;
                        state_next = ACC;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            ovf     <= ovf_next;
            sum_q   <= sum_next;
            count_q <= count_next;
            ovf_q   <= ovf_out_next;
            valid_q <= valid_next;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a wide build (ACC_W=80, CNT_W=8) and a narrow build
// (ACC_W=64, CNT_W=2) share one stimulus stream and are checked against a frame-level model.
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_last = 1'b0;
    logic        drv_ready = 1'b0;
    logic [63:0] drv_data = '0;
    bit          rand_ready = 1'b0;
    logic [1:0]  state_a;
    logic [1:0]  state_b;
    logic [1:0]  idle_state;
    int          n_checks = 0;
    int          n_errors = 0;

    // Model: beats of the open frame, pending results {ovf, count, sum}, last taken results.
    logic [63:0] beats_q[$];
    logic [88:0] exp_qa[$];
    logic [66:0] exp_qb[$];
    logic [88:0] hold_a;
    logic [66:0] hold_b;
    bit          live = 1'b0;
    bit          last_accept = 1'b0;

    product_accumulator_if #(.IN_W(64), .ACC_W(80), .CNT_W(8)) bus_a ();
    product_accumulator_if #(.IN_W(64), .ACC_W(64), .CNT_W(2)) bus_b ();

    assign bus_a.in_valid  = drv_valid;
    assign bus_a.in_data   = drv_data;
    assign bus_a.in_last   = drv_last;
    assign bus_a.out_ready = drv_ready;
    assign bus_b.in_valid  = drv_valid;
    assign bus_b.in_data   = drv_data;
    assign bus_b.in_last   = drv_last;
    assign bus_b.out_ready = drv_ready;

    product_accumulator #(.IN_W(64), .ACC_W(80), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .state_dbg(state_a)
    );
    product_accumulator #(.IN_W(64), .ACC_W(64), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .state_dbg(state_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame result from plain arithmetic on the whole list of beats.
    function automatic void calc(input int acc_w, input int cnt_w,
                                 output logic [127:0] s, output int c, output bit o);
        logic [127:0] total;
        logic [127:0] lim;
        int           cmax;
        total = '0;
        foreach (beats_q[i]) total += 128'(beats_q[i]);
        lim = 128'd1 << acc_w;
        o   = (total >= lim);
`ifdef ACC_SAT_EN
        s = o ? lim - 128'd1 : total;
`else
        s = total & (lim - 128'd1);
`endif
        cmax = (1 << cnt_w) - 1;
        c    = (beats_q.size() > cmax) ? cmax : beats_q.size();
    endfunction

    // Runs at the falling edge: compare the DUTs, then apply the coming rising edge to the model.
    task automatic model_cycle();
        logic [127:0] s;
        int           c;
        bit           o;
        last_accept = 1'b0;
        if (live) begin
            check("in_ready_a", 128'(bus_a.in_ready), 128'(exp_qa.size() == 0));
            check("in_ready_b", 128'(bus_b.in_ready), 128'(exp_qb.size() == 0));
            check("out_valid_a", 128'(bus_a.out_valid), 128'(exp_qa.size() != 0));
            check("out_valid_b", 128'(bus_b.out_valid), 128'(exp_qb.size() != 0));
            check("result_a", 128'({bus_a.out_ovf, bus_a.out_count, bus_a.out_sum}),
                  128'(exp_qa.size() != 0 ? exp_qa[0] : hold_a));
            check("result_b", 128'({bus_b.out_ovf, bus_b.out_count, bus_b.out_sum}),
                  128'(exp_qb.size() != 0 ? exp_qb[0] : hold_b));
        end
        if (rst) begin
            beats_q.delete();
            exp_qa.delete();
            exp_qb.delete();
            hold_a = '0;
            hold_b = '0;
            live   = 1'b1;
        end else if (exp_qa.size() != 0) begin
            if (drv_ready) begin
                hold_a = exp_qa.pop_front();
                hold_b = exp_qb.pop_front();
            end
        end else if (drv_valid) begin
            beats_q.push_back(drv_data);
            last_accept = 1'b1;
            if (drv_last) begin
                calc(80, 8, s, c, o);
                exp_qa.push_back({o, 8'(c), s[79:0]});
                calc(64, 2, s, c, o);
                exp_qb.push_back({o, 2'(c), s[63:0]});
                beats_q.delete();
            end
        end
    endtask

    // Ends 1 time unit after a rising edge, where inputs are driven and literals sampled.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        if (rand_ready) drv_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        drv_valid = 1'b1;
        drv_data  = d;
        drv_last  = l;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 300);
        if (!last_accept) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: beat %0h not taken after %0d cycles", d, n);
        end
        drv_valid = 1'b0;
        drv_data  = {$urandom, $urandom};
        drv_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus_a.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 128'(bus_a.out_valid), 128'(1));
    endtask

    task automatic release_result(input string name);
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;
        check({name, "_valid_drop"}, 128'(bus_a.out_valid), 128'(0));
        check({name, "_ready_back"}, 128'(bus_a.in_ready), 128'(1));
    endtask

    initial begin
        logic [63:0] d;
        int          len;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 128'(bus_a.out_valid), 128'(0));
        check("rst_in_ready", 128'(bus_a.in_ready), 128'(1));
        check("rst_out_sum", 128'(bus_a.out_sum), 128'(0));
        check("rst_out_count", 128'(bus_a.out_count), 128'(0));
        idle_state = state_a;

        // Three-beat frame, then backpressure on the result.
        send_beat(64'd5, 1'b0);
        send_beat(64'd7, 1'b0);
        send_beat(64'h2468ACEE, 1'b1);
        check("f1_latency", 128'(bus_a.out_valid), 128'(1));
        check("f1_sum", 128'(bus_a.out_sum), 128'h2468ACFA);
        check("f1_count", 128'(bus_a.out_count), 128'(3));
        check("f1_ovf", 128'(bus_a.out_ovf), 128'(0));
        check("state_dbg_distinct", 128'(state_a != idle_state), 128'(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_in_ready", 128'(bus_a.in_ready), 128'(0));
            check("bp_sum_stable", 128'(bus_a.out_sum), 128'h2468ACFA);
        end
        release_result("f1");

        // Single-beat frame.
        send_beat(64'hFFFFFFFE00000001, 1'b1);
        wait_valid("f2");
        check("f2_sum", 128'(bus_a.out_sum), 128'hFFFFFFFE00000001);
        check("f2_count", 128'(bus_a.out_count), 128'(1));
        release_result("f2");

        // Overflow of the 64-bit accumulator; the 80-bit one just carries on.
        send_beat(64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_beat(64'd2, 1'b1);
        wait_valid("f3");
        check("f3_sum_a", 128'(bus_a.out_sum), 128'h1_0000_0000_0000_0001);
        check("f3_ovf_a", 128'(bus_a.out_ovf), 128'(0));
`ifdef ACC_SAT_EN
        check("f3_sum_b", 128'(bus_b.out_sum), 128'hFFFF_FFFF_FFFF_FFFF);
`else
        check("f3_sum_b", 128'(bus_b.out_sum), 128'(1));
`endif
        check("f3_ovf_b", 128'(bus_b.out_ovf), 128'(1));
        release_result("f3");

        // Reset mid-frame discards the partial sum.
        send_beat(64'd1, 1'b0);
        send_beat(64'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_beat(64'd4, 1'b0);
        send_beat(64'd6, 1'b1);
        wait_valid("f4");
        check("f4_sum", 128'(bus_a.out_sum), 128'(10));
        check("f4_count", 128'(bus_a.out_count), 128'(2));
        release_result("f4");

        // Beat counter saturation in the narrow build.
        for (int i = 0; i < 5; i++) send_beat(64'd1, 1'(i == 4));
        wait_valid("f5");
        check("f5_count_a", 128'(bus_a.out_count), 128'(5));
        check("f5_count_b", 128'(bus_b.out_count), 128'(3));
        check("f5_sum_b", 128'(bus_b.out_sum), 128'(5));
        release_result("f5");

        // Reset while a result is pending drops it.
        send_beat(64'd9, 1'b1);
        wait_valid("f6");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("f6_dropped", 128'(bus_a.out_valid), 128'(0));
        repeat (3) tick();

        // Random frames with random gaps and random downstream readiness.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 3))
                    0:       d = 64'($urandom_range(0, 1000));
                    1:       d = {$urandom, $urandom};
                    2:       d = {32'hFFFF_FFFF, $urandom};
                    default: d = '0;
                endcase
                send_beat(d, 1'(b == len - 1));
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        rand_ready = 1'b0;
        drv_ready  = 1'b1;
        repeat (5) tick();
        drv_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
